// File: rtl/ntlm_pkg.sv
// Shared definitions for the NTLM cracker SRAM path: memory geometry and the
// result-reader state encoding.
package ntlm_pkg;

    localparam int unsigned SRAM_ADDR_W = 10;
    localparam int unsigned SRAM_DATA_W = 128;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_READ,
        RD_WAIT_DATA,
        RD_SEND,
        RD_WAIT_TX,
        RD_DONE
    } reader_state_t;

    // Width of a byte index over nbytes bytes, never narrower than one bit.
    function automatic int unsigned byte_idx_width(input int unsigned nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/sram_result_reader_if.sv
// SRAM read port plus the byte/strobe/done handshake towards tx_data, as seen
// by the result reader (master) and by the SRAM/transmitter side (slave).
interface sram_result_reader_if #(
    parameter int unsigned ADDR_W = ntlm_pkg::SRAM_ADDR_W,
    parameter int unsigned DATA_W = ntlm_pkg::SRAM_DATA_W
);

    logic              read_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] read_data;
    logic [7:0]        out_byte;
    logic              shift_out;
    logic              tx_done;

    modport master (
        output read_enable,
        output address,
        input  read_data,
        output out_byte,
        output shift_out,
        input  tx_done
    );

    modport slave (
        input  read_enable,
        input  address,
        output read_data,
        input  out_byte,
        input  shift_out,
        output tx_done
    );

endinterface

// File: rtl/sram_result_reader_word_byte_shifter.sv
// Holds one SRAM word and walks through it MSB byte first: load, shift left by
// one byte, and flag when the byte currently on top is the word's last.
module word_byte_shifter
    import ntlm_pkg::*;
#(
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    output logic [7:0]        next_byte_o,
    output logic              last_byte_o
);

    localparam int unsigned BYTES_PER_WORD = DATA_W / 8;
    localparam int unsigned IDX_W          = byte_idx_width(BYTES_PER_WORD);

    logic [DATA_W-1:0] word_q, word_d, shifted;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_comb begin
        shifted = word_q << 8;
        word_d  = word_q;
        idx_d   = idx_q;
        if (load_i) begin
            word_d = data_i;
            idx_d  = '0;
        end else if (shift_i) begin
            word_d = shifted;
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    // Byte that becomes the top byte after the next shift.
    assign next_byte_o = shifted[DATA_W-1 -: 8];
    assign last_byte_o = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/sram_result_reader.sv
// Streams entry_count SRAM words, MSB byte first, into the UART transmitter.
// Build option: define RESULT_READER_NULL_SKIP_EN to drop 0x00 padding bytes.
module sram_result_reader
    import ntlm_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              clear,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] entry_count,
    output logic              busy,
    output logic              done,
    sram_result_reader_if.master bus
);

`ifdef RESULT_READER_NULL_SKIP_EN
    localparam bit NULL_SKIP = 1'b1;
`else
    localparam bit NULL_SKIP = 1'b0;
`endif

    reader_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] words_q;
    logic              read_en_q;
    logic              shift_out_q;
    logic              skip_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        out_byte_q;

    logic              sh_load;
    logic              byte_adv;
    logic [7:0]        sh_next_byte;
    logic              sh_last;
    logic [7:0]        send_byte;
    logic              send_skip;

    word_byte_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk         (clk),
        .n_rst       (n_rst),
        .load_i      (sh_load),
        .data_i      (bus.read_data),
        .shift_i     (byte_adv),
        .next_byte_o (sh_next_byte),
        .last_byte_o (sh_last)
    );

    // A skipped zero byte in SEND completes exactly like a tx_done in WAIT_TX.
    always_comb begin
        sh_load  = 1'b0;
        byte_adv = 1'b0;
        if (!clear) begin
            sh_load  = (state_q == RD_WAIT_DATA);
            byte_adv = ((state_q == RD_WAIT_TX) && bus.tx_done) ||
                       ((state_q == RD_SEND) && skip_q);
        end
        send_byte = (state_q == RD_WAIT_DATA) ? bus.read_data[DATA_W-1 -: 8]
                                              : sh_next_byte;
        send_skip = NULL_SKIP && (send_byte == 8'h00);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            words_q     <= '0;
            read_en_q   <= 1'b0;
            shift_out_q <= 1'b0;
            skip_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_byte_q  <= '0;
        end else if (clear) begin
            state_q     <= RD_IDLE;
            read_en_q   <= 1'b0;
            shift_out_q <= 1'b0;
            skip_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            read_en_q   <= 1'b0;
            shift_out_q <= 1'b0;
            skip_q      <= 1'b0;
            done_q      <= 1'b0;

            unique case (state_q)
                RD_IDLE: begin
                    if (start) begin
                        addr_q  <= start_addr;
                        words_q <= entry_count;
                        busy_q  <= 1'b1;
                        if (entry_count == '0) begin
                            state_q <= RD_DONE;
                        end else begin
                            state_q   <= RD_READ;
                            read_en_q <= 1'b1;
                        end
                    end
                end
                RD_READ: state_q <= RD_WAIT_DATA;
                RD_WAIT_DATA: begin
                    state_q     <= RD_SEND;
                    shift_out_q <= !send_skip;
                    skip_q      <= send_skip;
                    if (!send_skip) out_byte_q <= send_byte;
                end
                RD_SEND: begin
                    if (!skip_q) state_q <= RD_WAIT_TX;
                end
                RD_WAIT_TX: begin
                end
                // Entered with done_q low only for an empty dump: one settle
                // cycle, then the pulse, then back to IDLE.
                RD_DONE: begin
                    if (done_q) begin
                        state_q <= RD_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase

            if (byte_adv) begin
                if (!sh_last) begin
                    state_q     <= RD_SEND;
                    shift_out_q <= !send_skip;
                    skip_q      <= send_skip;
                    if (!send_skip) out_byte_q <= send_byte;
                end else begin
                    words_q <= words_q - 1'b1;
                    addr_q  <= addr_q + 1'b1;
                    if (words_q == ADDR_W'(1)) begin
                        state_q <= RD_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= RD_READ;
                        read_en_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.read_enable = read_en_q;
    assign bus.address     = addr_q;
    assign bus.out_byte    = out_byte_q;
    assign bus.shift_out   = shift_out_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_sram_result_reader.sv
// Directed bench for sram_result_reader: SRAM model, tx_done responder and
// hand-computed byte streams for each dump scenario.
module tb_sram_result_reader;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       clear;
    logic [9:0] start_addr;
    logic [9:0] entry_count;
    logic       busy;
    logic       done;

    sram_result_reader_if #(.ADDR_W(10), .DATA_W(128)) bus ();

    sram_result_reader #(.ADDR_W(10), .DATA_W(128)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .clear       (clear),
        .start_addr  (start_addr),
        .entry_count (entry_count),
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    logic [127:0] mem [0:1023];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.read_enable) bus.read_data <= mem[bus.address];
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] byte_q [$];
    logic [9:0] rd_addr_q [$];
    int         strobe_idx [$];
    int         tx_idx [$];
    int         done_cnt;
    int         done_idx;
    int         busy_cycles;
    int         end_idx;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_read_enable"}, bus.read_enable, 1'b0);
        check_eq({tag, "_address"},     bus.address,     10'd0);
        check_eq({tag, "_out_byte"},    bus.out_byte,    8'h00);
        check_eq({tag, "_shift_out"},   bus.shift_out,   1'b0);
        check_eq({tag, "_busy"},        busy,            1'b0);
        check_eq({tag, "_done"},        done,            1'b0);
    endtask

    task automatic do_start(input logic [9:0] a, input logic [9:0] n);
        @(negedge clk);
        start       = 1'b1;
        start_addr  = a;
        entry_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples at each negedge starting with the cycle after start; answers each
    // strobe with a one-cycle tx_done tx_lat cycles later, optionally with clear.
    task automatic run_dump(input int tx_lat, input int clear_byte, input int budget);
        int cnt = 0;
        int idx = 0;
        bit fin = 1'b0;
        byte_q.delete();
        rd_addr_q.delete();
        strobe_idx.delete();
        tx_idx.delete();
        done_cnt    = 0;
        done_idx    = -1;
        busy_cycles = 0;
        end_idx     = -1;
        while (!fin && idx < budget) begin
            bus.tx_done = 1'b0;
            clear       = 1'b0;
            if (bus.shift_out) begin
                byte_q.push_back(bus.out_byte);
                strobe_idx.push_back(idx);
                cnt = tx_lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.tx_done = 1'b1;
                    tx_idx.push_back(idx);
                    if (byte_q.size() == clear_byte) clear = 1'b1;
                end
            end
            if (bus.read_enable) rd_addr_q.push_back(bus.address);
            if (done) begin
                done_cnt++;
                done_idx = idx;
            end
            if (busy) begin
                busy_cycles++;
            end else begin
                fin     = 1'b1;
                end_idx = idx;
            end
            if (!fin) begin
                @(negedge clk);
                idx++;
            end
        end
        bus.tx_done = 1'b0;
        clear       = 1'b0;
        check_eq("dump_finished", fin, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int strobes;
        int dones;
        int reads;

        n_rst       = 1'b0;
        start       = 1'b0;
        clear       = 1'b0;
        start_addr  = '0;
        entry_count = '0;
        bus.tx_done = 1'b0;
        bus.read_data = '0;

        mem[5]    = 128'h4142434445464748494A4B4C4D4E4F50;
        mem[1023] = 128'h808182838485868788898A8B8C8D8E8F;
        mem[0]    = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
        mem[7]    = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
        mem[8]    = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
        mem[9]    = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
        mem[11]   = 128'h61620000000000000000000000000000;

        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Single word at address 5, slow transmitter.
        do_start(10'd5, 10'd1);
        run_dump(20, -1, 1000);
        check_eq("t1_strobes", byte_q.size(), 16);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("t1_byte%0d", i), byte_q[i], 8'h41 + i);
        check_eq("t1_reads", rd_addr_q.size(), 1);
        check_eq("t1_read_addr", rd_addr_q[0], 10'd5);
        check_eq("t1_first_strobe_cycle", strobe_idx[0], 2);
        check_eq("t1_next_byte_latency", strobe_idx[1], tx_idx[0] + 1);
        check_eq("t1_done_count", done_cnt, 1);
        check_eq("t1_done_cycle", done_idx, tx_idx[15] + 1);
        check_eq("t1_busy_fall", end_idx, done_idx + 1);

        // Empty dump.
        do_start(10'd3, 10'd0);
        run_dump(4, -1, 50);
        check_eq("t2_reads", rd_addr_q.size(), 0);
        check_eq("t2_done_count", done_cnt, 1);
        check_eq("t2_done_cycle", done_idx, 1);
        check_eq("t2_busy_cycles", busy_cycles, 2);

        // Address wrap 1023 -> 0.
        do_start(10'd1023, 10'd2);
        run_dump(3, -1, 1000);
        check_eq("t3_strobes", byte_q.size(), 32);
        check_eq("t3_reads", rd_addr_q.size(), 2);
        check_eq("t3_read_addr0", rd_addr_q[0], 10'd1023);
        check_eq("t3_read_addr1", rd_addr_q[1], 10'd0);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("t3_w0_byte%0d", i), byte_q[i], 8'h80 + i);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("t3_w1_byte%0d", i), byte_q[16 + i], ((15 - i) << 4) | i);
        check_eq("t3_next_word_latency", strobe_idx[16], tx_idx[15] + 3);
        check_eq("t3_done_count", done_cnt, 1);

        // clear together with tx_done of the third byte.
        do_start(10'd5, 10'd1);
        run_dump(4, 3, 1000);
        check_eq("t4_strobes", byte_q.size(), 3);
        check_eq("t4_idle_cycle", end_idx, tx_idx[2] + 1);
        check_eq("t4_done_count", done_cnt, 0);
        strobes = 0;
        dones   = 0;
        reads   = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.shift_out) strobes++;
            if (done) dones++;
            if (bus.read_enable) reads++;
        end
        check_eq("t4_post_strobes", strobes, 0);
        check_eq("t4_post_done", dones, 0);
        check_eq("t4_post_reads", reads, 0);

        // Reset while waiting on the transmitter, then a fresh dump.
        do_start(10'd7, 10'd2);
        repeat (6) @(negedge clk);
        check_eq("t5_in_wait_tx_busy", busy, 1'b1);
        check_eq("t5_in_wait_tx_byte", bus.out_byte, 8'hA0);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        n_rst = 1'b1;
        do_start(10'd9, 10'd1);
        run_dump(2, -1, 500);
        check_eq("t5_reads", rd_addr_q.size(), 1);
        check_eq("t5_read_addr", rd_addr_q[0], 10'd9);
        check_eq("t5_strobes", byte_q.size(), 16);
        check_eq("t5_first_byte", byte_q[0], 8'hC0);
        check_eq("t5_last_byte", byte_q[15], 8'hCF);
        check_eq("t5_done_count", done_cnt, 1);

        // Zero-padded "ab" entry.
        do_start(10'd11, 10'd1);
        run_dump(2, -1, 500);
        check_eq("t6_byte0", byte_q[0], 8'h61);
        check_eq("t6_byte1", byte_q[1], 8'h62);
        check_eq("t6_done_count", done_cnt, 1);
`ifdef RESULT_READER_NULL_SKIP_EN
        check_eq("t6_strobes", byte_q.size(), 2);
`else
        check_eq("t6_strobes", byte_q.size(), 16);
        check_eq("t6_byte2", byte_q[2], 8'h00);
        check_eq("t6_byte15", byte_q[15], 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_result_reader.md
# sram_result_reader

Reads cracked-password entries back out of the on-chip SRAM and streams them byte by byte into the UART transmitter (`tx_data`), so the host can retrieve results. It is the read-side counterpart of the controller's SRAM writes. It sits between the SRAM wrapper's read port and the `pwd`/`passcrack`/`done_flag` interface of `tx_data`, and is started by the controller or host command logic.

## Interface
Parameters:
- `ADDR_W`, 10: SRAM word-address width.
- `DATA_W`, 128: SRAM word width; must be a multiple of 8.
- `BYTES_PER_WORD`, DATA_W/8 = 16: bytes sent per entry (derived, not overridable).

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a dump; ignored unless in IDLE.
- `clear`  in  1  synchronous abort; returns to IDLE next cycle with no `done`.
- `start_addr`  in  ADDR_W  first word address; sampled on accepted `start`.
- `entry_count`  in  ADDR_W  number of words to dump; sampled on accepted `start`.
- `read_enable`  out  1  SRAM read strobe.
- `address`  out  ADDR_W  SRAM word address.
- `read_data`  in  DATA_W  SRAM data, valid one cycle after `read_enable`.
- `out_byte`  out  8  byte to transmit; drives `tx_data.pwd`.
- `shift_out`  out  1  one-cycle load strobe; drives `tx_data.passcrack`.
- `tx_done`  in  1  transmitter byte-complete pulse (`tx_data.done_flag`).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last byte's `tx_done` is seen.

## Operation
- States: IDLE, READ, WAIT_DATA, SEND, WAIT_TX, DONE.
- IDLE: on `start`, latch `start_addr` into the address counter and `entry_count` into the word counter. If the count is 0, go to DONE; otherwise go to READ.
- READ: `read_enable`=1, `address`=current address for exactly one cycle, then WAIT_DATA.
- WAIT_DATA: capture `read_data` into a DATA_W shift register. Set the byte index to 0, then go to SEND.
- SEND: `shift_out`=1 for one cycle, with `out_byte`=shift_reg[DATA_W-1 -: 8] (MSB byte first). Then WAIT_TX.
- WAIT_TX: `out_byte` holds stable. When `tx_done`=1, shift the register left 8 and increment the byte index.
  - If more bytes remain in the word, go to SEND.
  - Else decrement the word count and increment the address, modulo 2^ADDR_W, so the address wraps from 2^ADDR_W-1 to 0. Go to READ if words remain, else DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `tx_done` outside WAIT_TX is ignored. `start` outside IDLE is ignored.
- `clear` has priority over every transition, including a simultaneous `tx_done` or `start`. Any byte already handed to the TX finishes on the wire.
- Reset values: `read_enable`=0, `address`=0, `out_byte`=0, `shift_out`=0, `busy`=0, `done`=0, state IDLE. An asserted `n_rst` mid-dump clears all state immediately.

## Timing
- `start` sampled at edge k: READ in cycle k+1, WAIT_DATA in k+2, first `shift_out` in cycle k+3.
- After `tx_done` sampled at edge m:
  - Next byte: `shift_out` in cycle m+1.
  - Next word: READ in m+1, `shift_out` in m+3.
- `done` is asserted the cycle after the final `tx_done`. `busy` falls the cycle after that.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `RESULT_READER_NULL_SKIP_EN` defined: zero bytes (0x00 padding of short passwords) are not transmitted. In SEND, a zero byte skips the strobe and is treated as an instantly completed byte, advancing in one cycle. A word that is all zero transmits nothing.
- Not defined: all BYTES_PER_WORD bytes of every word are transmitted, zeros included.

## Structure
- Shared package `ntlm_pkg` holds:
  - the `reader_state_t` enum;
  - the `SRAM_ADDR_W` and `SRAM_DATA_W` constants, which this block's defaults reference.
- One sub-module, `word_byte_shifter`: DATA_W load/shift-left-8 register with a byte counter and a `last_byte` flag. The FSM, address counter and word counter stay in the top.

## Test plan
- Single word 0x4142…50 at address 5, `entry_count`=1; bench pulses `tx_done` 20 cycles after each `shift_out` → bytes 0x41..0x50 in order; exactly 16 strobes; `done` once.
- `entry_count`=0 → no `read_enable`; `done` pulse 2 cycles after `start`; `busy` high for 2 cycles.
- `start_addr`=1023, `entry_count`=2 → reads at address 1023 then 0; 32 bytes sent.
- `clear` asserted in the same cycle as `tx_done` mid-word → IDLE next cycle; no further `shift_out`; no `done`.
- `n_rst` low during WAIT_TX, then `start` re-issued → all outputs at reset values; the fresh dump begins with the first byte of `start_addr`.
- With NULL_SKIP_EN, word "ab" padded with zeros → only 0x61 and 0x62 are strobed, then `done`. Without the macro, the same word → 16 strobes.
